alu_div_sequencer: RTL

Multi-cycle integer divide controller for UDIV/SDIV in the execute stage. Borrows the shared combinational Alu for 32 restoring-division iterations, issuing one subtract per cycle and keeping the partial remainder, quotient and sign handling locally. Sits beside the Alu. The execute-stage operand mux hands the Alu to this block while `alu_req` is high.

---
 rtl/alu_div_sequencer_if.sv | 42 ++++
 rtl/alu_div_sequencer.sv | 87 ++++++++
 2 files changed

// File: rtl/alu_div_sequencer_if.sv
// alu_div_sequencer_if: Alu types plus the divide request/result and Alu-borrow bus
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_t;
    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;
endpackage

interface alu_div_sequencer_if;
    import alu_pkg::*;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        alu_req;
    alu_op_t     alu_ops;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    alu_flags_t  alu_flags;
    modport master (
        output start, is_signed, dividend, divisor, alu_out, alu_flags,
        input  busy, done, quotient, remainder, div_by_zero,
               alu_req, alu_ops, alu_in1, alu_in2
    );
    modport slave (
        input  start, is_signed, dividend, divisor, alu_out, alu_flags,
        output busy, done, quotient, remainder, div_by_zero,
               alu_req, alu_ops, alu_in1, alu_in2
    );
endinterface

// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer: 34-cycle restoring UDIV/SDIV that borrows the shared Alu for its subtracts
module alu_div_sequencer
    import alu_pkg::*;
(
    input logic               clk,
    input logic               rst,
    alu_div_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;
    state_t      state;
    logic [31:0] r, q, d, dv;
    logic [4:0]  cnt;
    logic        neg_q, neg_r;
    logic        accept;
    logic [31:0] a_abs, b_abs, sh;
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign a_abs = (bus.is_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
    assign b_abs = (bus.is_signed && bus.divisor[31]) ? -bus.divisor : bus.divisor;
    assign sh = {r[30:0], d[31]};
    assign bus.alu_ops = ALU_SUB;
    // Alu operands are forced to zero whenever the Alu belongs to someone else
    assign bus.alu_in1 = bus.alu_req ? sh : '0;
    assign bus.alu_in2 = bus.alu_req ? dv : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            r               <= '0;
            q               <= '0;
            d               <= '0;
            dv              <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.alu_req     <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                d     <= a_abs;
                dv    <= b_abs;
                r     <= '0;
                q     <= '0;
                cnt   <= '0;
                neg_q <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
                neg_r <= bus.is_signed & bus.dividend[31];
                if (bus.divisor == '0) begin
                    state           <= DONE;
                    bus.done        <= 1'b1;
                    bus.quotient    <= '0;
                    bus.remainder   <= bus.dividend;
                    bus.div_by_zero <= 1'b1;
                end else begin
                    state           <= DIV;
                    bus.busy        <= 1'b1;
                    bus.alu_req     <= 1'b1;
                    bus.div_by_zero <= 1'b0;
                end
            end else begin
                case (state)
                    DIV: begin
                        r   <= bus.alu_flags.c ? bus.alu_out : sh;
                        q   <= {q[30:0], bus.alu_flags.c};
                        d   <= {d[30:0], 1'b0};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state       <= FIX;
                            bus.alu_req <= 1'b0;
                        end
                    end
                    FIX: begin
                        bus.quotient  <= neg_q ? -q : q;
                        bus.remainder <= neg_r ? -r : r;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DONE;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
